counter_ctrl: RTL and testbench

Front-end controller for the 8-bit up/down counter. Turns raw push-buttons and the enable switch into clean, single-cycle command pulses: load, a guarded clear, direction select, and a prescaled step tick. It sits between board I/O and the counter datapath and removes the accidental-press and bounce problems from it. All counter control signals come from this block; the counter sees only synchronous one-cycle strobes.

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/counter_ctrl_if.sv | 25 ++
 rtl/counter_ctrl_debounce.sv | 46 ++++
 rtl/counter_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter front-end controller.
// Clear-FSM state encodings, synchronizer depth and a counter-width helper.
package counter_ctrl_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_REL = 2'd2
  } clr_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Board-side buttons/switch and counter-side strobes of the counter controller.
// master is the controller view, slave the board/counter view.
interface counter_ctrl_if;

  logic enable;
  logic btn_clr;
  logic btn_load;
  logic btn_dir;
  logic cnt_clr;
  logic cnt_load;
  logic cnt_step;
  logic cnt_down;
  logic armed;

  modport master (
    input  enable, btn_clr, btn_load, btn_dir,
    output cnt_clr, cnt_load, cnt_step, cnt_down, armed
  );

  modport slave (
    output enable, btn_clr, btn_load, btn_dir,
    input  cnt_clr, cnt_load, cnt_step, cnt_down, armed
  );

endinterface

// File: rtl/counter_ctrl_debounce.sv
// Button conditioner: synchronizer, stability counter and rising-edge detect.
// level follows raw only after raw has disagreed with it for DEBOUNCE_CYC cycles.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int              DB_W   = cnt_w(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_TOP = DB_W'(DEBOUNCE_CYC);

  logic [SYNC_DEPTH-1:0] sync;
  logic [DB_W-1:0]       stable_cnt;
  logic                  raw_s;

  assign raw_s = sync[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      sync       <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], raw};
      rise <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (raw_s == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_TOP) begin
        level      <= raw_s;
        rise       <= raw_s;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Counter front-end: debounced buttons, enable-gated step prescaler and a
// hold-to-clear FSM, merged into prioritised one-cycle strobes (clear > load > step).
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int TICK_DIV     = 50000000,
  parameter int HOLD_CYC     = 50000000
) (
  input  logic           clk,
  input  logic           clr,
  counter_ctrl_if.master bus
);

  localparam int                PRE_W    = cnt_w(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(TICK_DIV - 1);
  localparam int                HOLD_W   = cnt_w(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_CYC - 1);

  logic clr_lvl, clr_rise;
  logic load_lvl, load_rise;
  logic dir_lvl, dir_rise;
  logic unused_lvls;

  logic [SYNC_DEPTH-1:0] en_sync;
  logic                  en_s;
  logic [PRE_W-1:0]      pre;

  clr_state_e        state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              clr_fire, load_hit, step_hit;

  logic cnt_clr_q, cnt_load_q, cnt_step_q, cnt_down_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk(clk), .clr(clr), .raw(bus.btn_clr), .level(clr_lvl), .rise(clr_rise)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_load (
    .clk(clk), .clr(clr), .raw(bus.btn_load), .level(load_lvl), .rise(load_rise)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dir (
    .clk(clk), .clr(clr), .raw(bus.btn_dir), .level(dir_lvl), .rise(dir_rise)
  );

  // Load and dir act on edges only; their levels are kept for probing.
  assign unused_lvls = ^{load_lvl, dir_lvl};

  assign en_s     = en_sync[SYNC_DEPTH-1];
  assign step_hit = en_s && (pre == PRE_TOP);
  assign load_hit = load_rise && en_s;

  // ---- clear FSM: state register ----
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
    end
  end

  // ---- clear FSM: next state and fire decision ----
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    clr_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_rise) begin
          state_nxt = ARM;
          hold_nxt  = '0;
        end
      end
      ARM: begin
        if (!clr_lvl) begin
          state_nxt = IDLE;
        end else if (hold == HOLD_TOP) begin
          clr_fire  = 1'b1;
          state_nxt = WAIT_REL;
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      WAIT_REL: begin
        if (!clr_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- prescaler, direction and registered strobes ----
  always_ff @(posedge clk) begin
    if (clr) begin
      en_sync    <= '0;
      pre        <= '0;
      cnt_clr_q  <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_step_q <= 1'b0;
      cnt_down_q <= 1'b0;
    end else begin
      en_sync    <= {en_sync[SYNC_DEPTH-2:0], bus.enable};
      cnt_clr_q  <= clr_fire;
      cnt_load_q <= load_hit && !clr_fire;
      cnt_step_q <= step_hit && !clr_fire && !load_hit;
      // A clear restarts the step phase and overrides a coincident dir toggle.
      if (clr_fire) begin
        pre        <= '0;
        cnt_down_q <= 1'b0;
      end else begin
        if (dir_rise) cnt_down_q <= !cnt_down_q;
        if (en_s) pre <= (pre == PRE_TOP) ? '0 : pre + PRE_W'(1);
      end
    end
  end

  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_step = cnt_step_q;
  assign bus.cnt_down = cnt_down_q;
  assign bus.armed    = (state == ARM);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DEBOUNCE_CYC=4, TICK_DIV=8, HOLD_CYC=16.
// Edge k of each loop is the k-th rising edge after the inputs for k were driven.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic clr;
  int   vectors = 0;
  int   miscompares = 0;

  counter_ctrl_if bus();

  counter_ctrl #(.DEBOUNCE_CYC(4), .TICK_DIV(8), .HOLD_CYC(16)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    bus.btn_clr  = 1'b0;
    bus.btn_load = 1'b0;
    bus.btn_dir  = 1'b0;
    bus.enable   = en;
    clr = 1'b1;
    tick;
    tick;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] got;
    bus.btn_clr = 1'b0; bus.btn_load = 1'b0; bus.btn_dir = 1'b0; bus.enable = 1'b0;
    clr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      got = {bus.cnt_clr, bus.cnt_load, bus.cnt_step, bus.cnt_down, bus.armed};
      vectors++;
      if (got !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs k=%0d got %b want 00000", k, got);
      end
    end
    clr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      got = {bus.cnt_clr, bus.cnt_load, bus.cnt_step, bus.cnt_down, bus.armed};
      vectors++;
      if (got !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_quiet k=%0d got %b want 00000", k, got);
      end
    end
  endtask

  task automatic test_bounce;
    logic [2:0] got, exp;
    do_reset(1'b1);
    for (int k = 1; k <= 26; k++) begin
      bus.btn_load = (k <= 10) ? (((k - 1) / 2) % 2 == 1) : 1'b1;
      tick;
      got = {bus.cnt_clr, bus.cnt_load, 1'b0};
      exp = {1'b0, (k == 18), 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bounce_load k=%0d clr/load got %b want %b", k, got, exp);
      end
    end
    bus.btn_load = 1'b0;
  endtask

  task automatic test_steps;
    int n_steps = 0;
    logic exp;
    do_reset(1'b1);
    for (int k = 1; k <= 70; k++) begin
      bus.enable = (k < 43) || (k > 62);
      tick;
      exp = (k == 10) || (k == 18) || (k == 26) || (k == 34) || (k == 42) || (k == 70);
      if (bus.cnt_step === 1'b1) n_steps++;
      vectors++;
      if (bus.cnt_step !== exp) begin
        miscompares++;
        $display("FAIL step_phase k=%0d cnt_step got %b want %b", k, bus.cnt_step, exp);
      end
    end
    vectors++;
    if (n_steps != 6) begin
      miscompares++;
      $display("FAIL step_count got %0d want 6", n_steps);
    end
  endtask

  task automatic test_direction;
    logic exp;
    do_reset(1'b1);
    for (int k = 1; k <= 20; k++) begin
      bus.btn_dir = (k <= 8);
      tick;
      exp = (k >= 8);
      vectors++;
      if (bus.cnt_down !== exp) begin
        miscompares++;
        $display("FAIL dir_first k=%0d cnt_down got %b want %b", k, bus.cnt_down, exp);
      end
    end
    bus.enable = 1'b0;
    for (int k = 1; k <= 4; k++) tick;
    for (int k = 1; k <= 20; k++) begin
      bus.btn_dir = (k <= 8);
      tick;
      exp = (k < 8);
      vectors++;
      if (bus.cnt_down !== exp) begin
        miscompares++;
        $display("FAIL dir_second_en0 k=%0d cnt_down got %b want %b", k, bus.cnt_down, exp);
      end
    end
    for (int k = 1; k <= 20; k++) begin
      bus.btn_load = (k <= 8);
      tick;
      vectors++;
      if ({bus.cnt_load, bus.cnt_step, bus.cnt_down} !== 3'b000) begin
        miscompares++;
        $display("FAIL load_en0 k=%0d load/step/down got %b want 000", k,
                 {bus.cnt_load, bus.cnt_step, bus.cnt_down});
      end
    end
  endtask

  task automatic test_clear;
    logic [2:0] got, exp;
    do_reset(1'b0);
    for (int k = 1; k <= 20; k++) begin
      bus.btn_dir = (k <= 8);
      tick;
    end
    vectors++;
    if (bus.cnt_down !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_pre_dir cnt_down got %b want 1", bus.cnt_down);
    end
    for (int k = 1; k <= 30; k++) begin
      bus.btn_clr = (k <= 10);
      tick;
      got = {bus.armed, bus.cnt_clr, bus.cnt_down};
      exp = {(k >= 8 && k <= 17), 1'b0, 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL clear_abort k=%0d armed/clr/down got %b want %b", k, got, exp);
      end
    end
    for (int k = 1; k <= 45; k++) begin
      bus.btn_clr = (k <= 30);
      tick;
      got = {bus.armed, bus.cnt_clr, bus.cnt_down};
      exp = {(k >= 8 && k <= 23), (k == 24), (k < 24)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL clear_complete k=%0d armed/clr/down got %b want %b", k, got, exp);
      end
    end
  endtask

  task automatic test_collision;
    logic [3:0] got, exp;
    do_reset(1'b1);
    for (int k = 1; k <= 36; k++) begin
      bus.btn_clr  = (k >= 3);
      bus.btn_load = (k >= 19);
      tick;
      got = {bus.cnt_clr, bus.cnt_load, bus.cnt_step, bus.armed};
      exp[3:1] = (k == 26) ? 3'b100 : ((k == 10 || k == 18 || k == 34) ? 3'b001 : 3'b000);
      exp[0]   = (k >= 10 && k <= 25);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL collision k=%0d clr/load/step/armed got %b want %b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] got, exp;
    logic [4:0] all;
    do_reset(1'b1);
    for (int k = 1; k <= 12; k++) begin
      bus.btn_clr = 1'b1;
      tick;
    end
    vectors++;
    if (bus.armed !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_armed got %b want 1", bus.armed);
    end
    bus.btn_clr  = 1'b0;
    bus.btn_load = 1'b1;
    clr = 1'b1;
    tick;
    all = {bus.cnt_clr, bus.cnt_load, bus.cnt_step, bus.cnt_down, bus.armed};
    vectors++;
    if (all !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %b want 00000", all);
    end
    tick;
    clr = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      got = {bus.cnt_clr, bus.cnt_load, bus.cnt_step, bus.armed};
      exp = {1'b0, (k == 8), (k == 10), 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL held_through_reset k=%0d clr/load/step/armed got %b want %b", k, got, exp);
      end
    end
    bus.btn_load = 1'b0;
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_steps;
    test_direction;
    test_clear;
    test_collision;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
